// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: steps serializer and output mux through
// start, data, optional parity and stop bit times, one bit per CLK cycle.
module uart_tx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Data_Valid,
  input  logic       PAR_EN,
  output logic       ser_load,
  output logic       ser_en,
  output logic [1:0] mux_sel,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);
  localparam logic LastStop = (STOP_BITS > 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
  logic            stop_cnt_q, stop_cnt_d;
  logic            par_en_q, par_en_d;

  logic [1:0] mux_sel_q, mux_sel_d;
  logic       busy_q, busy_d;
  logic       ser_load_q, ser_load_d;
  logic       ser_en_q, ser_en_d;
  logic       frame_done_q, frame_done_d;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_en_d   = par_en_q;
    case (state_q)
      StIdle: begin
        if (Data_Valid) begin
          state_d  = StStart;
          par_en_d = PAR_EN;
        end
      end
      StStart: begin
        state_d   = StData;
        bit_cnt_d = '0;
      end
      StData: begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == LastBit) begin
          state_d    = par_en_q ? StParity : StStop;
          stop_cnt_d = 1'b0;
        end
      end
      StParity: begin
        state_d    = StStop;
        stop_cnt_d = 1'b0;
      end
      StStop: begin
        if (stop_cnt_q == LastStop) begin
          // Back-to-back frames skip IDLE entirely.
          if (Data_Valid) begin
            state_d  = StStart;
            par_en_d = PAR_EN;
          end else begin
            state_d = StIdle;
          end
        end else begin
          stop_cnt_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the next state so the registers line up with state_q.
  always_comb begin
    mux_sel_d    = 2'b01;
    busy_d       = 1'b0;
    ser_load_d   = 1'b0;
    ser_en_d     = 1'b0;
    frame_done_d = 1'b0;
    case (state_d)
      StStart: begin
        mux_sel_d  = 2'b00;
        busy_d     = 1'b1;
        ser_load_d = 1'b1;
      end
      StData: begin
        mux_sel_d = 2'b10;
        busy_d    = 1'b1;
        ser_en_d  = 1'b1;
      end
      StParity: begin
        mux_sel_d = 2'b11;
        busy_d    = 1'b1;
      end
      StStop: begin
        busy_d       = 1'b1;
        frame_done_d = (stop_cnt_d == LastStop);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      par_en_q     <= 1'b0;
      mux_sel_q    <= 2'b01;
      busy_q       <= 1'b0;
      ser_load_q   <= 1'b0;
      ser_en_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      par_en_q     <= par_en_d;
      mux_sel_q    <= mux_sel_d;
      busy_q       <= busy_d;
      ser_load_q   <= ser_load_d;
      ser_en_q     <= ser_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign mux_sel    = mux_sel_q;
  assign busy       = busy_q;
  assign ser_load   = ser_load_q;
  assign ser_en     = ser_en_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: one-stop and two-stop instances driven together and
// compared each cycle against a frame-position reference model.
module tb_uart_tx_ctrl;

  localparam int DW = 8;

  logic CLK, RST, dv, par_en;
  logic       ld1, en1, busy1, done1;
  logic [1:0] mux1;
  logic       ld2, en2, busy2, done2;
  logic [1:0] mux2;
  logic [5:0] o1, o2;

  int checks = 0;
  int passes = 0;

  uart_tx_ctrl #(.DATA_WIDTH(DW), .STOP_BITS(1)) dut (
    .CLK(CLK), .RST(RST), .Data_Valid(dv), .PAR_EN(par_en),
    .ser_load(ld1), .ser_en(en1), .mux_sel(mux1), .busy(busy1), .frame_done(done1)
  );

  uart_tx_ctrl #(.DATA_WIDTH(DW), .STOP_BITS(2)) dut2 (
    .CLK(CLK), .RST(RST), .Data_Valid(dv), .PAR_EN(par_en),
    .ser_load(ld2), .ser_en(en2), .mux_sel(mux2), .busy(busy2), .frame_done(done2)
  );

  assign o1 = {mux1, busy1, ld1, en1, done1};
  assign o2 = {mux2, busy2, ld2, en2, done2};

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Model: a frame is a sequence of positions 0..len-1; k=0 one stop, k=1 two.
  bit m_act[2];
  int m_pos[2];
  bit m_par[2];

  function automatic int m_len(input int k);
    return 1 + DW + int'(m_par[k]) + k + 1;
  endfunction

  always @(posedge CLK or negedge RST) begin
    for (int k = 0; k < 2; k++) begin
      if (!RST) begin
        m_act[k] <= 1'b0;
        m_pos[k] <= 0;
        m_par[k] <= 1'b0;
      end else if (!m_act[k] || m_pos[k] == m_len(k) - 1) begin
        m_act[k] <= dv;
        m_pos[k] <= 0;
        if (dv) m_par[k] <= par_en;
      end else begin
        m_pos[k] <= m_pos[k] + 1;
      end
    end
  end

  // {mux_sel, busy, ser_load, ser_en, frame_done}
  function automatic logic [5:0] model_out(input int k);
    int p;
    p = m_pos[k];
    if (!m_act[k]) return 6'b01_0000;
    if (p == 0) return 6'b00_1100;
    if (p <= DW) return 6'b10_1010;
    if (m_par[k] && p == DW + 1) return 6'b11_1000;
    return {2'b01, 1'b1, 1'b0, 1'b0, (p == m_len(k) - 1)};
  endfunction

  task automatic test_reset();
    RST = 1'b0;
    dv = 1'b0;
    par_en = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (o1 !== 6'b01_0000) $display("FAIL reset1 got %b want %b", o1, 6'b01_0000);
    else passes++;
    checks++;
    if (o2 !== 6'b01_0000) $display("FAIL reset2 got %b want %b", o2, 6'b01_0000);
    else passes++;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_single(input logic par);
    int nb1 = 0, ne1 = 0, nl1 = 0, nd1 = 0, dcyc = -1, nb2 = 0, nd2 = 0;
    dv = 1'b1;
    par_en = par;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      checks++;
      if (o1 !== model_out(0)) $display("FAIL single%0d c%0d d1 got %b want %b", par, i, o1, model_out(0));
      else passes++;
      checks++;
      if (o2 !== model_out(1)) $display("FAIL single%0d c%0d d2 got %b want %b", par, i, o2, model_out(1));
      else passes++;
      nb1 += int'(busy1); ne1 += int'(en1); nl1 += int'(ld1); nd1 += int'(done1);
      nb2 += int'(busy2); nd2 += int'(done2);
      if (done1) dcyc = i;
      if (i == 0) dv = 1'b0;
    end
    checks++;
    if (nb1 != 10 + int'(par)) $display("FAIL single%0d busy_len got %0d want %0d", par, nb1, 10 + int'(par));
    else passes++;
    checks++;
    if (ne1 != DW) $display("FAIL single%0d ser_en_len got %0d want %0d", par, ne1, DW);
    else passes++;
    checks++;
    if (nl1 != 1 || nd1 != 1) $display("FAIL single%0d pulses got load %0d done %0d want 1 1", par, nl1, nd1);
    else passes++;
    checks++;
    if (dcyc != 9 + int'(par)) $display("FAIL single%0d done_cycle got %0d want %0d", par, dcyc, 9 + int'(par));
    else passes++;
    checks++;
    if (nb2 != 11 + int'(par) || nd2 != 1) $display("FAIL single%0d stop2 got busy %0d done %0d want %0d 1", par, nb2, nd2, 11 + int'(par));
    else passes++;
  endtask

  task automatic test_back_to_back();
    int nl = 0, nb = 0;
    dv = 1'b1;
    par_en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      checks++;
      if (o1 !== model_out(0)) $display("FAIL b2b c%0d d1 got %b want %b", i, o1, model_out(0));
      else passes++;
      checks++;
      if (o2 !== model_out(1)) $display("FAIL b2b c%0d d2 got %b want %b", i, o2, model_out(1));
      else passes++;
      if (i < 33) begin
        nl += int'(ld1);
        nb += int'(busy1);
      end
      if (i == 32) dv = 1'b0;
    end
    checks++;
    if (nl != 3 || nb != 33) $display("FAIL b2b got loads %0d busy %0d want 3 33", nl, nb);
    else passes++;
  endtask

  task automatic test_par_change();
    int np1 = 0, np2 = 0, nb = 0;
    dv = 1'b1;
    par_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      checks++;
      if (o1 !== model_out(0)) $display("FAIL parchg c%0d d1 got %b want %b", i, o1, model_out(0));
      else passes++;
      checks++;
      if (o2 !== model_out(1)) $display("FAIL parchg c%0d d2 got %b want %b", i, o2, model_out(1));
      else passes++;
      np1 += int'(mux1 == 2'b11);
      np2 += int'(mux2 == 2'b11);
      nb += int'(busy1);
      if (i == 0) dv = 1'b0;
      if (i == 3) par_en = 1'b0;
      if (i == 13) dv = 1'b1;
      if (i == 14) dv = 1'b0;
    end
    checks++;
    if (np1 != 1 || np2 != 1 || nb != 21) $display("FAIL parchg got par %0d/%0d busy %0d want 1/1 21", np1, np2, nb);
    else passes++;
  endtask

  task automatic test_ignore();
    int nl = 0, nb = 0;
    dv = 1'b1;
    par_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      checks++;
      if (o1 !== model_out(0)) $display("FAIL ignore c%0d d1 got %b want %b", i, o1, model_out(0));
      else passes++;
      checks++;
      if (o2 !== model_out(1)) $display("FAIL ignore c%0d d2 got %b want %b", i, o2, model_out(1));
      else passes++;
      nl += int'(ld1) + int'(ld2);
      nb += int'(busy1);
      if (i == 0) dv = 1'b0;
      if (i == 5) dv = 1'b1;
      if (i == 6) dv = 1'b0;
    end
    checks++;
    if (nl != 2 || nb != 10) $display("FAIL ignore got loads %0d busy %0d want 2 10", nl, nb);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int nb = 0;
    dv = 1'b1;
    par_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (i == 0) dv = 1'b0;
    end
    checks++;
    if (mux1 !== 2'b11) $display("FAIL rstmid in_parity got %b want %b", mux1, 2'b11);
    else passes++;
    #2 RST = 1'b0;
    #1;
    checks++;
    if (o1 !== 6'b01_0000) $display("FAIL rstmid async1 got %b want %b", o1, 6'b01_0000);
    else passes++;
    checks++;
    if (o2 !== 6'b01_0000) $display("FAIL rstmid async2 got %b want %b", o2, 6'b01_0000);
    else passes++;
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      checks++;
      if (o1 !== 6'b01_0000 || o2 !== 6'b01_0000) $display("FAIL rstmid idle c%0d got %b %b want 010000", i, o1, o2);
      else passes++;
    end
    dv = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      checks++;
      if (o1 !== model_out(0)) $display("FAIL rstmid frame c%0d d1 got %b want %b", i, o1, model_out(0));
      else passes++;
      checks++;
      if (o2 !== model_out(1)) $display("FAIL rstmid frame c%0d d2 got %b want %b", i, o2, model_out(1));
      else passes++;
      nb += int'(busy1);
      if (i == 0) dv = 1'b0;
    end
    checks++;
    if (nb != 11) $display("FAIL rstmid frame_len got %0d want 11", nb);
    else passes++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      checks++;
      if (o1 !== model_out(0)) $display("FAIL random c%0d d1 got %b want %b", i, o1, model_out(0));
      else passes++;
      checks++;
      if (o2 !== model_out(1)) $display("FAIL random c%0d d2 got %b want %b", i, o2, model_out(1));
      else passes++;
      dv = ($urandom_range(0, 3) == 0);
      par_en = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single(1'b0);
    test_single(1'b1);
    test_back_to_back();
    test_par_change();
    test_ignore();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Frame sequencer for the UART transmitter. It accepts a Data_Valid request, then steps the serializer and the output multiplexer through start, data, optional parity and stop bit times, one bit per CLK cycle. CLK is the TX bit clock. The block drives the mux select encoding 00=start, 01=stop/idle, 10=serial data, 11=parity, and reports busy and frame completion to the host side.

Parameters:
DATA_WIDTH, 8, data bits per frame (1..16); sizes the internal bit counter.
STOP_BITS, 1, stop bit times per frame (1 or 2).

Ports:
CLK  input  1  TX bit clock; all state changes on the rising edge.
RST  input  1  asynchronous, active-low reset.
Data_Valid  input  1  request to send the word currently presented to the serializer and parity blocks.
PAR_EN  input  1  parity enable; sampled only on frame accept.
ser_load  output  1  one-cycle pulse: serializer and parity block capture the input word.
ser_en  output  1  serializer shift enable; high for exactly DATA_WIDTH cycles per frame.
mux_sel  output  2  output mux select (00 start, 01 stop/idle, 10 data, 11 parity).
busy  output  1  high from the START state through the final stop cycle.
frame_done  output  1  one-cycle pulse in the final stop cycle.

Behaviour:
- All outputs are registered and decoded from the current state (Moore). The downstream mux adds one more register stage, so TX_OUT follows mux_sel by 1 cycle.
- Reset values: state=IDLE, mux_sel=01, busy=0, ser_load=0, ser_en=0, frame_done=0, bit_cnt=0, stop_cnt=0, par_en_q=0.
- State IDLE: mux_sel=01, busy=0.
  - Data_Valid=1 at an edge: next state is START, PAR_EN is latched into par_en_q, and ser_load pulses high for the START cycle.
- State START: exactly 1 cycle. mux_sel=00, busy=1, ser_load=1. Next state is DATA with bit_cnt=0.
- State DATA: mux_sel=10, ser_en=1, busy=1.
  - bit_cnt increments each cycle.
  - When bit_cnt==DATA_WIDTH-1, the next state is PARITY if par_en_q=1, otherwise STOP.
  - The block stays in DATA for exactly DATA_WIDTH cycles.
- State PARITY: exactly 1 cycle. mux_sel=11, ser_en=0, busy=1. Next state is STOP with stop_cnt=0.
- State STOP: mux_sel=01, busy=1, for STOP_BITS cycles. In the final stop cycle frame_done=1.
  - At the end of the final stop cycle, Data_Valid=1 goes to START: a back-to-back frame with no idle gap. PAR_EN is re-latched and ser_load pulses in that START.
  - Otherwise the next state is IDLE.
- Frame length in cycles = 1 + DATA_WIDTH + par_en_q + STOP_BITS (START entry to last STOP).
- Data_Valid in any state other than IDLE or the final stop cycle is ignored. It is not queued; the host must hold or reissue it.
- PAR_EN changes mid-frame have no effect on the current frame.
- Data_Valid held continuously high produces continuous frames. busy never drops between them.
- Reset asserted mid-frame: the block immediately (asynchronously) returns to IDLE with all reset values, and the partial frame is abandoned. After release, the block waits in IDLE for a new Data_Valid.
- DATA_WIDTH=1: DATA lasts a single cycle (bit_cnt compare at 0).
- Illegal or unused state encodings recover to IDLE on the next edge.

Test Plan:
- Reset then Data_Valid pulse for 1 cycle, PAR_EN=0, DATA_WIDTH=8 -> mux_sel sequence 00, 10×8, 01, then 01 idle. busy high for 10 cycles. ser_en high for 8. ser_load 1 pulse. frame_done pulse in cycle 10.
- Same with PAR_EN=1 -> 00, 10×8, 11, 01. busy high for 11 cycles. frame_done in cycle 11.
- Data_Valid held high for 3 frames, PAR_EN=1 -> 3 contiguous 11-cycle frames, no 01 idle between them, busy constant 1, exactly 3 ser_load pulses.
- PAR_EN toggled 1→0 during DATA of a frame accepted with PAR_EN=1 -> parity cycle still present. The next frame, accepted with PAR_EN=0, has no parity cycle.
- Data_Valid pulsed during DATA bit 4 -> ignored: one frame only, return to IDLE, no ser_load.
- RST asserted during PARITY -> outputs immediately mux_sel=01, busy=0, ser_en=0. After release with Data_Valid=0, stays idle. A subsequent Data_Valid produces a full, correct frame.
- STOP_BITS=2, PAR_EN=0 -> two 01 cycles before IDLE. frame_done only in the second.
